// File: rtl/iob_soc_opencryptolinux_mem_arbiter.sv
// Two-master to one-slave IOb arbiter: round-robin grant, one outstanding read,
// read responses routed back to the master that issued the read.
module iob_soc_opencryptolinux_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                cke_i,
  input  logic                m0_avalid_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_rvalid_o,
  output logic                m0_ready_o,
  input  logic                m1_avalid_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_rvalid_o,
  output logic                m1_ready_o,
  output logic                s_avalid_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  input  logic [DATA_W-1:0]   s_rdata_i,
  input  logic                s_rvalid_i,
  input  logic                s_ready_i
);

  typedef enum logic {IDLE = 1'b0, WAIT_RD = 1'b1} state_t;

  state_t state, state_next;
  logic   owner, owner_next;
  logic   last, last_next;
  logic   lock, lock_next;
  logic   lock_id, lock_id_next;
  logic   grant;
  logic   run;
  logic   accept;
  logic   rsp;

  assign run = cke_i & ~arst_i;

  // A request stalled by s_ready_i keeps the grant until it is accepted, so the
  // request seen by memory never changes underneath it.
  always_comb begin
    grant = m1_avalid_i;
    if (lock && (lock_id ? m1_avalid_i : m0_avalid_i)) begin
      grant = lock_id;
    end else if (m0_avalid_i && m1_avalid_i) begin
      grant = ~last;
    end
  end

  assign s_avalid_o = run & (state == IDLE) & (m0_avalid_i | m1_avalid_i);
  assign s_addr_o   = grant ? m1_addr_i  : m0_addr_i;
  assign s_wdata_o  = grant ? m1_wdata_i : m0_wdata_i;
  assign s_wstrb_o  = grant ? m1_wstrb_i : m0_wstrb_i;

  assign accept     = s_avalid_o & s_ready_i;
  assign m0_ready_o = accept & ~grant;
  assign m1_ready_o = accept & grant;

  assign rsp         = s_rvalid_i & (state == WAIT_RD) & ~arst_i;
  assign m0_rvalid_o = rsp & ~owner;
  assign m1_rvalid_o = rsp & owner;
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  always_comb begin
    state_next   = state;
    owner_next   = owner;
    last_next    = last;
    lock_next    = lock;
    lock_id_next = lock_id;
    if (cke_i) begin
      lock_next    = s_avalid_o & ~s_ready_i;
      lock_id_next = grant;
      case (state)
        IDLE: begin
          if (accept) begin
            last_next = grant;
            if (s_wstrb_o == '0) begin
              state_next = WAIT_RD;
              owner_next = grant;
            end
          end
        end
        WAIT_RD: begin
          if (s_rvalid_i) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // last resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      lock    <= 1'b0;
      lock_id <= 1'b0;
    end else begin
      state   <= state_next;
      owner   <= owner_next;
      last    <= last_next;
      lock    <= lock_next;
      lock_id <= lock_id_next;
    end
  end

endmodule

// File: tb/tb_iob_soc_opencryptolinux_mem_arbiter.sv
// Self-checking bench: reset/grant vector table, directed multi-cycle sequences,
// and randomized traffic checked against a transaction-level arbiter model.
module tb_iob_soc_opencryptolinux_mem_arbiter;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        cke = 1'b1;
  logic        m0_avalid, m1_avalid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rvalid, m1_rvalid, m0_ready, m1_ready;
  logic        s_avalid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata;
  logic        s_rvalid, s_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iob_soc_opencryptolinux_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .arst_i(arst), .cke_i(cke),
    .m0_avalid_i(m0_avalid), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_wstrb_i(m0_wstrb), .m0_rdata_o(m0_rdata), .m0_rvalid_o(m0_rvalid),
    .m0_ready_o(m0_ready),
    .m1_avalid_i(m1_avalid), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_wstrb_i(m1_wstrb), .m1_rdata_o(m1_rdata), .m1_rvalid_o(m1_rvalid),
    .m1_ready_o(m1_ready),
    .s_avalid_o(s_avalid), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_wstrb_o(s_wstrb), .s_rdata_i(s_rdata), .s_rvalid_i(s_rvalid),
    .s_ready_i(s_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_avalid = 0; m1_avalid = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    m0_wstrb = 0; m1_wstrb = 0;
    s_ready = 1; s_rvalid = 0; s_rdata = 0; cke = 1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    arst = 1;
    idle_inputs();
    #2;
    arst = 0;
    #1;
  endtask

  typedef struct {
    logic m0v, m1v;
    logic [3:0] m0s, m1s;
    logic srdy, srv, ck;
    logic e_sav, e_r0, e_r1, e_rv0, e_rv1;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[8];

  // randomized-phase model state
  bit          mv[2];
  logic [31:0] ma[2], mw[2];
  logic [3:0]  ms[2];
  int          rd_q[$];
  int          stall;
  int          last_m;
  int          rd_cnt;
  int          g;
  bit          pend, e_sav, e_acc, srv_b;
  bit          e_rv[2];

  initial begin
    arst = 0;
    idle_inputs();
    vecs[0] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10};
    vecs[1] = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20};
    vecs[2] = '{1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10};
    vecs[3] = '{1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10};
    vecs[4] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20};

    // Each vector is applied right out of reset (last = 1, IDLE).
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      arst = 1;
      m0_avalid = vecs[i].m0v; m1_avalid = vecs[i].m1v;
      m0_wstrb = vecs[i].m0s;  m1_wstrb = vecs[i].m1s;
      m0_addr = 32'h10; m1_addr = 32'h20;
      s_ready = vecs[i].srdy; s_rvalid = vecs[i].srv; cke = vecs[i].ck;
      s_rdata = 32'hA5A5_0000 + i;
      #1;
      chk($sformatf("v%0d_in_reset", i), {s_avalid, m0_ready, m1_ready, m0_rvalid, m1_rvalid}, 5'b0);
      arst = 0;
      #1;
      chk($sformatf("v%0d_outs", i), {s_avalid, m0_ready, m1_ready, m0_rvalid, m1_rvalid},
          {vecs[i].e_sav, vecs[i].e_r0, vecs[i].e_r1, vecs[i].e_rv0, vecs[i].e_rv1});
      if (vecs[i].e_sav) chk($sformatf("v%0d_addr", i), s_addr, vecs[i].e_addr);
      $display("vector %0d applied", i);
    end

    // Single read from m0, data returned 3 cycles after acceptance.
    do_reset();
    m0_avalid = 1; m0_addr = 32'h100; m0_wstrb = 0;
    #2;
    chk("rd_m0_ready", m0_ready, 1);
    chk("rd_s_addr", s_addr, 32'h100);
    tick();
    m0_avalid = 0;
    for (int c = 0; c < 2; c++) begin
      #2;
      chk("rd_wait_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
      tick();
    end
    s_rvalid = 1; s_rdata = 32'hDEADBEEF;
    #2;
    chk("rd_rvalid", {m0_rvalid, m1_rvalid}, 2'b10);
    chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
    tick();
    s_rvalid = 0;
    #2;
    chk("rd_rvalid_once", {m0_rvalid, m1_rvalid}, 2'b00);
    $display("seq single_read done");

    // Simultaneous reads after reset: m0 first, m1 after m0's response.
    do_reset();
    m0_avalid = 1; m0_addr = 32'h10; m1_avalid = 1; m1_addr = 32'h20;
    #2;
    chk("sim_grant0", {m0_ready, m1_ready}, 2'b10);
    chk("sim_addr0", s_addr, 32'h10);
    tick();
    m0_avalid = 0;
    #2;
    chk("sim_blocked", {s_avalid, m1_ready}, 2'b00);
    tick();
    s_rvalid = 1; s_rdata = 32'h1111;
    #2;
    chk("sim_rsp0", {m0_rvalid, m1_rvalid, m1_ready}, 3'b100);
    tick();
    s_rvalid = 0;
    #2;
    chk("sim_grant1", {m0_ready, m1_ready}, 2'b01);
    chk("sim_addr1", s_addr, 32'h20);
    tick();
    m1_avalid = 0;
    s_rvalid = 1; s_rdata = 32'h2222;
    #2;
    chk("sim_rsp1", {m0_rvalid, m1_rvalid}, 2'b01);
    chk("sim_rdata1", m1_rdata, 32'h2222);
    tick();
    s_rvalid = 0;
    $display("seq simultaneous_reads done");

    // Round-robin writes from both masters.
    do_reset();
    m0_avalid = 1; m0_addr = 32'hA0; m0_wstrb = 4'hF;
    m1_avalid = 1; m1_addr = 32'hB0; m1_wstrb = 4'hF;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk($sformatf("rr_grant%0d", c), {m0_ready, m1_ready}, (c % 2 == 0) ? 2'b10 : 2'b01);
      chk($sformatf("rr_addr%0d", c), s_addr, (c % 2 == 0) ? 32'hA0 : 32'hB0);
      chk($sformatf("rr_rvalid%0d", c), {m0_rvalid, m1_rvalid}, 2'b00);
      tick();
    end
    idle_inputs();
    $display("seq round_robin done");

    // Backpressure on an m1 write; m0 arrives mid-stall.
    do_reset();
    m1_avalid = 1; m1_addr = 32'hC0; m1_wstrb = 4'h3; s_ready = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        m0_avalid = 1; m0_addr = 32'hD0; m0_wstrb = 4'hF;
      end
      #2;
      chk($sformatf("bp_stall%0d", c), {s_avalid, m0_ready, m1_ready}, 3'b100);
      chk($sformatf("bp_addr%0d", c), s_addr, 32'hC0);
      tick();
    end
    s_ready = 1;
    #2;
    chk("bp_accept", {m0_ready, m1_ready}, 2'b01);
    tick();
    m1_avalid = 0;
    #2;
    chk("bp_next_m0", {m0_ready, m1_ready}, 2'b10);
    tick();
    m0_avalid = 0;
    $display("seq backpressure done");

    // m1 blocked while m0's read is outstanding.
    do_reset();
    m0_avalid = 1; m0_addr = 32'h40;
    #2;
    chk("blk_m0_ready", m0_ready, 1);
    tick();
    m0_avalid = 0; m1_avalid = 1; m1_addr = 32'h50; m1_wstrb = 4'hF;
    for (int c = 0; c < 2; c++) begin
      #2;
      chk($sformatf("blk_wait%0d", c), {s_avalid, m1_ready}, 2'b00);
      tick();
    end
    s_rvalid = 1; s_rdata = 32'h5555;
    #2;
    chk("blk_rsp", {m0_rvalid, m1_ready, s_avalid}, 3'b100);
    tick();
    s_rvalid = 0;
    #2;
    chk("blk_m1_accept", m1_ready, 1);
    tick();
    m1_avalid = 0;
    $display("seq blocking done");

    // Reset while a read is outstanding; late response must be dropped.
    do_reset();
    m0_avalid = 1; m0_addr = 32'h60;
    #2;
    chk("rmr_m0_ready", m0_ready, 1);
    tick();
    m0_avalid = 0;
    tick();
    arst = 1;
    #1;
    chk("rmr_in_reset", {s_avalid, m0_ready, m1_ready, m0_rvalid, m1_rvalid}, 5'b0);
    arst = 0;
    s_rvalid = 1;
    #1;
    chk("rmr_late_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    tick();
    s_rvalid = 0; m1_avalid = 1; m1_addr = 32'h70; m1_wstrb = 4'h1;
    #2;
    chk("rmr_m1_accept", m1_ready, 1);
    tick();
    m1_avalid = 0;
    $display("seq reset_mid_read done");

    // Randomized traffic against a transaction-level model.
    do_reset();
    mv[0] = 0; mv[1] = 0;
    rd_q.delete();
    stall = -1; last_m = 1; rd_cnt = -1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (!mv[k] && $urandom_range(0, 99) < 40) begin
          mv[k] = 1;
          ma[k] = $urandom;
          mw[k] = $urandom;
          ms[k] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        end
      end
      srv_b = (rd_cnt == 0);
      s_rvalid = srv_b;
      s_rdata = $urandom;
      s_ready = ($urandom_range(0, 3) != 0);
      cke = srv_b ? 1'b1 : ($urandom_range(0, 9) != 0);
      m0_avalid = mv[0]; m0_addr = ma[0]; m0_wdata = mw[0]; m0_wstrb = ms[0];
      m1_avalid = mv[1]; m1_addr = ma[1]; m1_wdata = mw[1]; m1_wstrb = ms[1];
      #2;
      pend = (rd_q.size() > 0);
      if (stall >= 0 && mv[stall]) g = stall;
      else if (mv[0] && mv[1]) g = (last_m == 1) ? 0 : 1;
      else g = mv[1] ? 1 : 0;
      e_sav = cke && !pend && (mv[0] || mv[1]);
      e_acc = e_sav && s_ready;
      for (int k = 0; k < 2; k++) e_rv[k] = s_rvalid && pend && (rd_q[0] == k);
      chk("rnd_s_avalid", s_avalid, e_sav);
      chk("rnd_ready", {m0_ready, m1_ready}, {e_acc && g == 0, e_acc && g == 1});
      chk("rnd_rvalid", {m0_rvalid, m1_rvalid}, {e_rv[0], e_rv[1]});
      if (e_sav) begin
        chk("rnd_s_addr", s_addr, ma[g]);
        chk("rnd_s_wdata", s_wdata, mw[g]);
        chk("rnd_s_wstrb", s_wstrb, ms[g]);
      end
      if (e_rv[0]) chk("rnd_m0_rdata", m0_rdata, s_rdata);
      if (e_rv[1]) chk("rnd_m1_rdata", m1_rdata, s_rdata);
      if (srv_b) rd_cnt = -1;
      else if (rd_cnt > 0) rd_cnt--;
      if (cke) begin
        if (pend && s_rvalid) rd_q.delete();
        if (e_acc) begin
          $display("txn cyc %0d m%0d %s addr %h", cyc, g, (ms[g] == 0) ? "read" : "write", ma[g]);
          last_m = g;
          if (ms[g] == 0) begin
            rd_q.push_back(g);
            rd_cnt = $urandom_range(0, 3);
          end
          mv[g] = 0;
        end
        stall = (e_sav && !s_ready) ? g : -1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_soc_opencryptolinux_mem_arbiter.md
Name: iob_soc_opencryptolinux_mem_arbiter

Overview:
- Two-master to one-slave IOb-native arbiter with round-robin grant and one outstanding read.
- Sits directly upstream of the external-memory controller. Merges the CPU instruction-bus and data-bus external-memory slaves of the bus splits into a single IOb port, so the external-memory controller and AXI master need only one request channel.
- Routes each read response back to the master that issued it.

Parameters:
- ADDR_W, 32, request address width (bits).
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk_i  in  1  system clock
- arst_i  in  1  reset
- cke_i  in  1  clock enable; when low all state is frozen
- m0_avalid_i  in  1  master 0 (instruction) request valid
- m0_addr_i  in  ADDR_W  master 0 address
- m0_wdata_i  in  DATA_W  master 0 write data
- m0_wstrb_i  in  DATA_W/8  master 0 write strobe; 0 = read
- m0_rdata_o  out  DATA_W  master 0 read data
- m0_rvalid_o  out  1  master 0 read data valid
- m0_ready_o  out  1  master 0 request accepted
- m1_*  same set as m0_*  master 1 (data)
- s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o  out  1/ADDR_W/DATA_W/DATA_W/8  merged request to memory
- s_rdata_i  in  DATA_W  memory read data
- s_rvalid_i  in  1  memory read data valid
- s_ready_i  in  1  memory accepts request

Interface: one clock (clk_i); reset arst_i is asynchronous and active-high.

Behaviour:
- Handshake rules:
  - A request is accepted in a cycle where mk_avalid_i & mk_ready_o = 1.
  - Masters hold avalid, addr, wdata and wstrb stable until accepted.
  - Writes produce no response.
  - A read produces exactly one s_rvalid_i pulse, one or more cycles after acceptance.
- State machine (registered, 1 bit): IDLE, WAIT_RD.
  - IDLE -> WAIT_RD on acceptance of a read (wstrb == 0).
  - IDLE -> IDLE on acceptance of a write.
  - WAIT_RD -> IDLE in the cycle after s_rvalid_i = 1.
  - No request is accepted in a cycle that has s_rvalid_i = 1.
- Registers:
  - owner (1 bit): master of the outstanding read, captured on read acceptance.
  - last (1 bit): last granted master, updated on every acceptance.
- Grant (combinational, IDLE only):
  - If only one master has avalid, it is granted.
  - If both have avalid, the master != last is granted.
  - No avalid: no grant; s_avalid_o = 0.
- Request path:
  - In IDLE, the s_* request outputs equal the granted master's inputs, with zero added latency.
  - In WAIT_RD, s_avalid_o = 0.
  - mk_ready_o = IDLE & grant==k & s_ready_i; the non-granted master's ready is 0.
- Response path:
  - m{owner}_rvalid_o = s_rvalid_i & (state == WAIT_RD).
  - The other master's rvalid = 0.
  - Both mk_rdata_o = s_rdata_i (qualified by rvalid).
  - s_rvalid_i in IDLE is ignored: no mk_rvalid_o.
- Back-to-back:
  - Writes may be accepted every cycle while s_ready_i = 1, alternating masters when both request.
  - Minimum read-to-next-request gap is 1 cycle after rvalid.
- cke_i = 0:
  - State, owner and last hold.
  - All mk_ready_o = 0 and s_avalid_o = 0.
  - rvalid routing stays combinational.
- Reset values (applied immediately by arst_i, async):
  - state = IDLE, owner = 0, last = 1, so master 0 wins the first tie.
  - While arst_i = 1, all outputs are 0: s_avalid_o, mk_ready_o, mk_rvalid_o.
  - Reset mid-read drops the outstanding read; a late s_rvalid_i after reset is ignored (IDLE).

Test Plan:
- Single read: m0 read addr 0x100, s_ready_i = 1, memory returns 0xDEADBEEF 3 cycles later -> m0_ready_o = 1 in the issue cycle; m0_rvalid_o = 1 with m0_rdata_o = 0xDEADBEEF in exactly one cycle; m1_rvalid_o stays 0.
- Simultaneous requests after reset: m0 read 0x10 and m1 read 0x20 in the same cycle -> m0 granted first (s_addr_o = 0x10); m1 granted the cycle after m0's rvalid (s_addr_o = 0x20); the response goes to m1 only.
- Round-robin writes: m0 and m1 both hold writes (wstrb = 0xF) for 4 cycles with s_ready_i = 1 -> grants alternate m0, m1, m0, m1; no rvalid on either master.
- Backpressure: m1 write with s_ready_i = 0 for 5 cycles, then 1 -> s_avalid_o = 1 throughout; m1_ready_o = 0 for 5 cycles, then 1 for one cycle; grant stays on m1 even if m0 raises avalid mid-stall.
- Blocking while a read is outstanding: m0 read outstanding, m1 write presented -> m1_ready_o = 0 and s_avalid_o = 0 until the cycle after s_rvalid_i; then m1 is accepted.
- Reset mid-read: arst_i pulsed while in WAIT_RD, then s_rvalid_i = 1 -> no mk_rvalid_o asserted; the next m1 request is accepted immediately.
